// File: rtl/rx_pkt_regs.sv
// Receive packet buffer with a byte-wide register interface.
// Bytes land in a circular buffer; completed packet lengths queue in a small length FIFO.
module rx_pkt_regs #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned MAX_PKTS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic [2:0] addr,
  input  logic       wr,
  input  logic [7:0] wr_data,
  input  logic       rd,
  output logic [7:0] rd_data,
  output logic       int_n
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;
  localparam int unsigned PW = $clog2(MAX_PKTS + 1);

  localparam logic [2:0] AddrStatus = 3'd0;
  localparam logic [2:0] AddrCtrl   = 3'd1;
  localparam logic [2:0] AddrPktLen = 3'd2;
  localparam logic [2:0] AddrRxData = 3'd3;
  localparam logic [2:0] AddrPktCnt = 3'd4;

  typedef enum logic [1:0] {StIdle, StRecv, StDiscard} state_e;

  logic [7:0]    mem_q     [DEPTH];
  logic [CW-1:0] len_mem_q [MAX_PKTS];

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] pkt_start_q, pkt_start_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] open_cnt_q, open_cnt_d;
  logic [CW-1:0] head_off_q, head_off_d;
  logic [LW-1:0] len_wr_q, len_wr_d;
  logic [LW-1:0] len_rd_q, len_rd_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          ovf_q, ovf_d;
  logic          int_en_q, int_en_d;
  logic          int_n_q, int_n_d;
  logic [7:0]    rd_data_q, rd_data_d;

  logic          rd_en, flush, buf_full, pkt_full, accept, store, commit, overflow;
  logic          pop, pop_last;
  logic [CW-1:0] head_len, pkt_len;

  function automatic logic [LW-1:0] len_inc(input logic [LW-1:0] p);
    return (p == LW'(MAX_PKTS - 1)) ? '0 : p + LW'(1);
  endfunction

  always_comb begin
    // A simultaneous write wins over the read.
    rd_en    = rd && !wr;
    flush    = wr && (addr == AddrCtrl) && wr_data[1];
    buf_full = (occ_q == CW'(DEPTH));
    pkt_full = (pkt_cnt_q == PW'(MAX_PKTS));
    in_ready = !rst && !flush && ((state_q == StDiscard) || (!buf_full && !pkt_full));
    accept   = in_valid && in_ready;
    store    = accept && (state_q != StDiscard);
    commit   = store && in_last;
    overflow = store && !in_last && (state_q == StRecv) && (open_cnt_q + CW'(1) == CW'(DEPTH));
    head_len = len_mem_q[len_rd_q];
    pkt_len  = (pkt_cnt_q != '0) ? head_len - head_off_q : '0;
    pop      = rd_en && (addr == AddrRxData) && (pkt_cnt_q != '0);
    pop_last = pop && (head_off_q + CW'(1) == head_len);
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_start_d = pkt_start_q;
    occ_d       = occ_q + CW'(store) - CW'(pop);
    open_cnt_d  = open_cnt_q;
    head_off_d  = head_off_q;
    len_wr_d    = len_wr_q;
    len_rd_d    = len_rd_q;
    pkt_cnt_d   = pkt_cnt_q + PW'(commit) - PW'(pop_last);
    ovf_d       = ovf_q;
    int_en_d    = int_en_q;
    int_n_d     = !(int_en_q && (pkt_cnt_q != '0));
    rd_data_d   = rd_data_q;

    if (store) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      open_cnt_d = open_cnt_q + CW'(1);
    end

    unique case (state_q)
      StIdle:    if (store && !in_last) state_d = StRecv;
      StRecv:    if (commit) state_d = StIdle;
                 else if (overflow) state_d = StDiscard;
      StDiscard: if (accept && in_last) state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (commit) begin
      open_cnt_d  = '0;
      pkt_start_d = wr_ptr_q + AW'(1);
      len_wr_d    = len_inc(len_wr_q);
    end

    // Oversized packet: drop everything written for it, including this byte.
    if (overflow) begin
      wr_ptr_d   = pkt_start_q;
      open_cnt_d = '0;
      occ_d      = occ_q - open_cnt_q - CW'(pop);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      head_off_d = head_off_q + CW'(1);
    end
    if (pop_last) begin
      head_off_d = '0;
      len_rd_d   = len_inc(len_rd_q);
    end

    if (wr && (addr == AddrStatus) && wr_data[2]) ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;
    if (wr && (addr == AddrCtrl)) int_en_d = wr_data[0];

    if (rd_en) begin
      case (addr)
        AddrStatus: rd_data_d = {5'b0, ovf_q, buf_full, pkt_cnt_q != '0};
        AddrCtrl:   rd_data_d = {7'b0, int_en_q};
        AddrPktLen: rd_data_d = 8'(pkt_len);
        AddrRxData: rd_data_d = pop ? mem_q[rd_ptr_q] : 8'h00;
        AddrPktCnt: rd_data_d = 8'(pkt_cnt_q);
        default:    rd_data_d = 8'h00;
      endcase
    end

    if (flush) begin
      state_d     = StIdle;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pkt_start_d = '0;
      occ_d       = '0;
      open_cnt_d  = '0;
      head_off_d  = '0;
      len_wr_d    = '0;
      len_rd_d    = '0;
      pkt_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_start_q <= '0;
      occ_q       <= '0;
      open_cnt_q  <= '0;
      head_off_q  <= '0;
      len_wr_q    <= '0;
      len_rd_q    <= '0;
      pkt_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      int_en_q    <= 1'b1;
      int_n_q     <= 1'b1;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_start_q <= pkt_start_d;
      occ_q       <= occ_d;
      open_cnt_q  <= open_cnt_d;
      head_off_q  <= head_off_d;
      len_wr_q    <= len_wr_d;
      len_rd_q    <= len_rd_d;
      pkt_cnt_q   <= pkt_cnt_d;
      ovf_q       <= ovf_d;
      int_en_q    <= int_en_d;
      int_n_q     <= int_n_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= in_data;
    if (commit) len_mem_q[len_wr_q] <= open_cnt_q + CW'(1);
  end

  assign rd_data = rd_data_q;
  assign int_n   = int_n_q;

endmodule
